// File: rtl/bus_scheduler.sv
// rtl/bus_scheduler.sv - round-robin bus arbiter with split-transaction parking
// Optional watchdog enabled by defining BUS_SCHED_TIMEOUT_EN.
module bus_scheduler #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_i_1,
    input  logic       req_i_2,
    input  logic       req_split,
    input  logic       split_start,
    input  logic       split_done,
    output logic       grant_i_1,
    output logic       grant_i_2,
    output logic       grant_split,
    output logic [1:0] sel,
    output logic [1:0] split_owner,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {IDLE, GNT1, GNT2, GNTS} state_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_I1   = 2'b01;
    localparam logic [1:0] OWN_I2   = 2'b10;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 1023) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 2..1023");
    end

    state_t     state, state_n;
    logic [1:0] owner_n;
    logic       last_i2, last_i2_n;
    logic       req1_m, req2_m;

    // A parked initiator may not win arbitration until its split completes.
    assign req1_m = req_i_1 && (split_owner != OWN_I1);
    assign req2_m = req_i_2 && (split_owner != OWN_I2);

`ifdef BUS_SCHED_TIMEOUT_EN
    localparam logic [9:0] WD_LIMIT = 10'(TIMEOUT_CYCLES - 1);
    logic [9:0] wd_cnt, wd_cnt_n;
    logic       timeout_n;
`endif

    always_comb begin
        state_n   = state;
        owner_n   = split_owner;
        last_i2_n = last_i2;
        unique case (state)
            IDLE: begin
                if (split_owner != OWN_NONE && req_split) begin
                    state_n = GNTS;
                end else if (req1_m && (!req2_m || last_i2)) begin
                    state_n   = GNT1;
                    last_i2_n = 1'b0;
                end else if (req2_m) begin
                    state_n   = GNT2;
                    last_i2_n = 1'b1;
                end
            end
            GNT1: begin
                if (split_start && split_owner == OWN_NONE) begin
                    state_n = IDLE;
                    owner_n = OWN_I1;
                end else if (!req_i_1) begin
                    state_n = IDLE;
                end
            end
            GNT2: begin
                if (split_start && split_owner == OWN_NONE) begin
                    state_n = IDLE;
                    owner_n = OWN_I2;
                end else if (!req_i_2) begin
                    state_n = IDLE;
                end
            end
            GNTS: begin
                if (split_done) begin
                    state_n = IDLE;
                    owner_n = OWN_NONE;
                end else if (!req_split) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
`ifdef BUS_SCHED_TIMEOUT_EN
        // Expiry only matters when the grant would otherwise be held.
        timeout_n = (state != IDLE) && (state_n == state) && (wd_cnt == WD_LIMIT);
        if (timeout_n) begin
            state_n = IDLE;
            if (state == GNTS) begin
                owner_n = OWN_NONE;
            end
        end
        wd_cnt_n = (state == IDLE || state_n != state) ? 10'd0 : wd_cnt + 10'd1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            split_owner <= OWN_NONE;
            last_i2     <= 1'b1;
            grant_i_1   <= 1'b0;
            grant_i_2   <= 1'b0;
            grant_split <= 1'b0;
            sel         <= 2'b11;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            split_owner <= owner_n;
            last_i2     <= last_i2_n;
            grant_i_1   <= (state_n == GNT1);
            grant_i_2   <= (state_n == GNT2);
            grant_split <= (state_n == GNTS);
            busy        <= (state_n != IDLE);
            unique case (state_n)
                GNT1:    sel <= 2'b00;
                GNT2:    sel <= 2'b01;
                GNTS:    sel <= 2'b10;
                default: sel <= 2'b11;
            endcase
        end
    end

`ifdef BUS_SCHED_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt  <= 10'd0;
            timeout <= 1'b0;
        end else begin
            wd_cnt  <= wd_cnt_n;
            timeout <= timeout_n;
        end
    end
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_bus_scheduler.sv
// tb/tb_bus_scheduler.sv - directed and randomized checks of bus_scheduler against a reference model
module tb_bus_scheduler;

    localparam int T = 8;

    logic       clk = 1'b0;
    logic       rst, req_i_1, req_i_2, req_split, split_start, split_done;
    logic       grant_i_1, grant_i_2, grant_split, busy, timeout;
    logic [1:0] sel, split_owner;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: holder 0 = bus free, 1/2 = initiator, 3 = split target.
    int   m_hold, m_park, m_last;
    logic m_to;
`ifdef BUS_SCHED_TIMEOUT_EN
    int   m_wd;
`endif

    bus_scheduler #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst),
        .req_i_1(req_i_1), .req_i_2(req_i_2), .req_split(req_split),
        .split_start(split_start), .split_done(split_done),
        .grant_i_1(grant_i_1), .grant_i_2(grant_i_2), .grant_split(grant_split),
        .sel(sel), .split_owner(split_owner), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_hold = 0;
        m_park = 0;
        m_last = 2;
        m_to   = 1'b0;
`ifdef BUS_SCHED_TIMEOUT_EN
        m_wd   = 0;
`endif
    endtask

    task automatic model_step();
        int nh;
        bit r1, r2;
        nh   = m_hold;
        m_to = 1'b0;
        r1   = req_i_1 && (m_park != 1);
        r2   = req_i_2 && (m_park != 2);
        if (m_hold == 0) begin
            if (m_park != 0 && req_split)  nh = 3;
            else if (r1 && r2)             nh = (m_last == 1) ? 2 : 1;
            else if (r1)                   nh = 1;
            else if (r2)                   nh = 2;
            if (nh == 1 || nh == 2) m_last = nh;
        end else if (m_hold == 3) begin
            if (split_done) begin
                m_park = 0;
                nh = 0;
            end else if (!req_split) begin
                nh = 0;
            end
        end else begin
            if (split_start && m_park == 0) begin
                m_park = m_hold;
                nh = 0;
            end else if (!((m_hold == 1) ? req_i_1 : req_i_2)) begin
                nh = 0;
            end
        end
`ifdef BUS_SCHED_TIMEOUT_EN
        if (m_hold != 0 && nh == m_hold) begin
            if (m_wd == T - 1) begin
                if (m_hold == 3) m_park = 0;
                nh   = 0;
                m_to = 1'b1;
                m_wd = 0;
            end else begin
                m_wd++;
            end
        end else begin
            m_wd = 0;
        end
`endif
        m_hold = nh;
    endtask

    function automatic logic [8:0] expected_vec();
        logic [1:0] s;
        s = (m_hold == 0) ? 2'b11 : 2'(m_hold - 1);
        return {m_hold == 1, m_hold == 2, m_hold == 3, s, 2'(m_park), m_hold != 0, m_to};
    endfunction

    task automatic cycle(input string tag);
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        #1;
        check(tag, {grant_i_1, grant_i_2, grant_split, sel, split_owner, busy, timeout}, expected_vec());
    endtask

    initial begin
        int g_cnt, t_cnt, exp_g, exp_t;
        rst = 1'b1; req_i_1 = 1'b0; req_i_2 = 1'b0; req_split = 1'b0;
        split_start = 1'b0; split_done = 1'b0;
        model_reset();

        cycle("reset");
        check("rst_grants", {grant_i_1, grant_i_2, grant_split}, 3'b000);
        check("rst_sel", sel, 2'b11);
        check("rst_owner", split_owner, 2'b00);
        check("rst_busy_to", {busy, timeout}, 2'b00);
        rst = 1'b0;

        // single owner
        req_i_1 = 1'b1;
        cycle("single_gnt");
        check("single_g1", grant_i_1, 1'b1);
        check("single_sel", sel, 2'b00);
        for (int i = 0; i < 4; i++) cycle("single_hold");
        req_i_1 = 1'b0;
        cycle("single_rel");
        check("single_rel_g1", grant_i_1, 1'b0);
        check("single_rel_sel", sel, 2'b11);

        // tie-break from reset
        rst = 1'b1;
        cycle("tie_rst");
        rst = 1'b0;
        req_i_1 = 1'b1; req_i_2 = 1'b1;
        cycle("tie_first");
        check("tie_first_g1", grant_i_1, 1'b1);
        req_i_1 = 1'b0;
        cycle("tie_turn");
        check("tie_turn_busy", busy, 1'b0);
        cycle("tie_second");
        check("tie_second_g2", grant_i_2, 1'b1);
        req_i_2 = 1'b0;
        cycle("tie_rel");
        req_i_1 = 1'b1; req_i_2 = 1'b1;
        cycle("tie_third");
        check("tie_third_g1", grant_i_1, 1'b1);
        req_i_1 = 1'b0; req_i_2 = 1'b0;
        cycle("tie_idle");

        // split park
        req_i_1 = 1'b1;
        cycle("park_gnt");
        split_start = 1'b1; req_i_2 = 1'b1;
        cycle("park_split");
        check("park_g1_low", grant_i_1, 1'b0);
        check("park_owner", split_owner, 2'b01);
        split_start = 1'b0;
        cycle("park_g2");
        check("park_g2_high", grant_i_2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle("park_hold");
            check("park_g1_never", grant_i_1, 1'b0);
        end

        // split return
        req_split = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle("ret_wait");
            check("ret_gs_wait", grant_split, 1'b0);
        end
        req_i_2 = 1'b0;
        cycle("ret_turn");
        check("ret_turn_busy", busy, 1'b0);
        cycle("ret_gnts");
        check("ret_gs", grant_split, 1'b1);
        check("ret_sel", sel, 2'b10);
        split_done = 1'b1; req_split = 1'b0;
        cycle("ret_done");
        check("ret_done_gs", grant_split, 1'b0);
        check("ret_done_owner", split_owner, 2'b00);
        split_done = 1'b0;
        cycle("ret_g1");
        check("ret_g1_high", grant_i_1, 1'b1);
        req_i_1 = 1'b0;
        cycle("ret_rel");

        // watchdog / indefinite hold
`ifdef BUS_SCHED_TIMEOUT_EN
        exp_g = 18; exp_t = 2;
`else
        exp_g = 20; exp_t = 0;
`endif
        g_cnt = 0; t_cnt = 0;
        req_i_1 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle("wd_run");
            if (grant_i_1) g_cnt++;
            if (timeout)   t_cnt++;
        end
        check("wd_grant_cycles", g_cnt, exp_g);
        check("wd_timeouts", t_cnt, exp_t);
        req_i_1 = 1'b0;
        cycle("wd_rel");
        cycle("wd_idle");

        // split_start beats a same-cycle request drop, then reset mid-split
        req_i_1 = 1'b1;
        cycle("rs_gnt");
        req_i_1 = 1'b0; split_start = 1'b1;
        cycle("rs_split");
        check("rs_owner_wins", split_owner, 2'b01);
        split_start = 1'b0; req_split = 1'b1;
        cycle("rs_gnts");
        check("rs_gs", grant_split, 1'b1);
        rst = 1'b1;
        cycle("rs_reset");
        check("rs_grants", {grant_i_1, grant_i_2, grant_split}, 3'b000);
        check("rs_sel", sel, 2'b11);
        check("rs_owner", split_owner, 2'b00);
        rst = 1'b0; req_split = 1'b0;
        cycle("rs_after");

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) req_i_1 = ~req_i_1;
            if ($urandom_range(0, 3) == 0) req_i_2 = ~req_i_2;
            if ($urandom_range(0, 4) == 0) req_split = ~req_split;
            split_start = ($urandom_range(0, 5) == 0);
            split_done  = ($urandom_range(0, 4) == 0);
            rst         = ($urandom_range(0, 299) == 0);
            cycle("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_scheduler.md
# bus_scheduler

Sequencing arbiter for the serial bus, shared by two initiator ports and one split-capable target port. Grants the bus round-robin between initiators. When a target splits, it parks the owning initiator and releases the bus. It returns the bus to the split target, with priority, once the target is ready to respond. Sits between the initiator/target ports and the bus mux, and drives `sel` to the mux and the address/data routing.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 64: watchdog limit in cycles of continuous grant (only used with `BUS_SCHED_TIMEOUT_EN`); valid range 2..1023.

Ports:
- `clk`  in  1  bus clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_i_1`  in  1  initiator 1 bus request (level).
- `req_i_2`  in  1  initiator 2 bus request (level).
- `req_split`  in  1  split target requests the bus to return read data (level).
- `split_start`  in  1  one-cycle pulse: current target issued split ack for the granted initiator.
- `split_done`  in  1  one-cycle pulse: split response transfer finished (target ack).
- `grant_i_1`  out  1  bus granted to initiator 1.
- `grant_i_2`  out  1  bus granted to initiator 2.
- `grant_split`  out  1  bus granted to split target.
- `sel`  out  2  mux select: 00 = init 1, 01 = init 2, 10 = split target, 11 = none.
- `split_owner`  out  2  parked initiator: 00 = none, 01 = init 1, 10 = init 2.
- `busy`  out  1  any grant active.
- `timeout`  out  1  one-cycle pulse on watchdog expiry; constant 0 without the macro.

## Operation
- FSM states: IDLE, GNT1, GNT2, GNTS. All outputs are registered and decoded from the state; at most one grant is high at a time.
- A request is masked while that initiator is the `split_owner`.
- IDLE:
  - If `split_owner != 00` and `req_split` → GNTS. The split target has priority over both initiators.
  - Otherwise, with unmasked requests: a single requester is granted. With two requesters, the initiator not granted last wins.
  - `last` is updated on each initiator grant; its reset value is init 2, so init 1 wins the first tie.
- GNT1/GNT2:
  - `split_start` → record owner in `split_owner` → IDLE.
  - Owner's `req` low → IDLE.
  - Otherwise hold.
  - When `split_start` and a request drop occur in the same cycle, `split_start` wins and the owner is recorded.
- GNTS:
  - `split_done` → clear `split_owner` → IDLE.
  - `req_split` low without `split_done` → IDLE, with `split_owner` kept.
- Ignored inputs:
  - `split_start` outside GNT1/GNT2.
  - `split_start` while `split_owner != 00`; only one split is outstanding.
  - `split_done` outside GNTS.
- `req_split` with `split_owner == 00` is ignored.

## Timing
- Reset values:
  - `state` = IDLE; all grants 0; `busy` 0; `timeout` 0.
  - `sel` = 11; `split_owner` = 00; `last` = init 2; watchdog counter 0.
- Reset asserted mid-grant: grants drop and `split_owner` clears at that edge.
- Grant latency: request high at edge k (sampled in IDLE) → grant high after edge k, i.e. one cycle after the request rises.
- Release: request low sampled at edge k → grant low after edge k.
- There is always at least one IDLE cycle between two grants (bus turnaround), including back-to-back grants to the same initiator.
- `split_start` at edge k → owner grant low after k; the next grant (another initiator or GNTS) no earlier than after k+1.
- `split_owner` updates at the same edge the state leaves GNT1/GNT2 or GNTS.

## Configuration
- Macro `BUS_SCHED_TIMEOUT_EN`, defined:
  - A 10-bit counter clears on entry to any grant state and increments each cycle in a grant state.
  - When it reaches `TIMEOUT_CYCLES`: force IDLE, pulse `timeout` for one cycle, and clear `split_owner` if the state was GNTS.
  - A still-asserted request is re-arbitrated normally after the IDLE cycle.
- Macro undefined: no counter, `timeout` tied 0, grants are held indefinitely.

## Test plan
- Single owner: `req_i_1` high 5 cycles from IDLE → `grant_i_1` high the next cycle and `sel` = 00. Drop `req_i_1` → `grant_i_1` low next edge, `sel` = 11.
- Tie-break: after reset, `req_i_1` and `req_i_2` rise together → `grant_i_1` first. After release, one IDLE cycle then `grant_i_2`. Release and raise both again → `grant_i_1`.
- Split park:
  - Stimulus: `grant_i_1` active, `split_start` pulse, `req_i_1` held high, `req_i_2` high.
  - Required: `grant_i_1` low next edge, `split_owner` = 01, `grant_i_2` after one IDLE cycle, `grant_i_1` never reasserted.
- Split return:
  - Stimulus: raise `req_split` while init 2 holds the bus, then release init 2.
  - Required: `grant_split` only after init 2 releases and one IDLE cycle, with `sel` = 10.
  - `split_done` pulse → `grant_split` low, `split_owner` = 00, `req_i_1` granted after one IDLE cycle.
- Watchdog: `BUS_SCHED_TIMEOUT_EN` defined, `TIMEOUT_CYCLES` = 8, `req_i_1` held 20 cycles.
  - Required: grant high for 8 cycles, `timeout` pulse, one IDLE cycle, then re-grant to init 1.
  - Macro undefined: grant stays high for all 20 cycles, `timeout` stays 0.
- Reset mid-split: `split_owner` = 01 and GNTS active, `rst` high one cycle → all grants 0, `sel` = 11, `split_owner` = 00 at that edge.
